// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: op codes for both modes and FSM states.
package alu_pkg;

   localparam logic [1:0] ADD  = 2'b00;
   localparam logic [1:0] SUB  = 2'b01;
   localparam logic [1:0] DIV  = 2'b10;
   localparam logic [1:0] MUL  = 2'b11;

   localparam logic [1:0] LAND = 2'b00;
   localparam logic [1:0] LOR  = 2'b01;
   localparam logic [1:0] LXOR = 2'b10;
   localparam logic [1:0] LNOT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Command/result bus of the sequential ALU: valid/ready on both the operand and result side.
interface seq_alu_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] f_hi;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             dz;

   modport master (
      output in_valid, mode, op, a, b, out_ready,
      input  in_ready, out_valid, f, f_hi, zero, carry, ovf, dz
   );

   modport slave (
      input  in_valid, mode, op, a, b, out_ready,
      output in_ready, out_valid, f, f_hi, zero, carry, ovf, dz
   );

endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle for WIDTH cycles.
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             run_q, div_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] lo_q, hi_q, opnd_q;
   logic [WIDTH-1:0] lo_d, hi_d;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] rem_sub;

   // MUL: {hi,lo} starts as {0,b}, add a into hi on lo[0], shift right.
   // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      lo_d    = lo_q;
      hi_d    = hi_q;
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_sub = {1'b0, rem_sh} - {2'b00, opnd_q};
      if (div_q) begin
         if (!rem_sub[WIDTH+1]) begin
            hi_d = rem_sub[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q  <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
         opnd_q <= '0;
      end else if (start_i) begin
         run_q  <= 1'b1;
         div_q  <= is_div_i;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= is_div_i ? a_i : b_i;
         opnd_q <= is_div_i ? b_i : a_i;
      end else if (run_q) begin
         lo_q  <= lo_d;
         hi_q  <= hi_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) run_q <= 1'b0;
      end
   end

   // Final step's result is exposed combinationally so the top can register it on the same edge.
   assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign lo_o   = lo_d;
   assign hi_o   = hi_d;

endmodule

// File: rtl/seq_alu.sv
// Handshaked unsigned ALU: single-cycle logic/ADD/SUB, WIDTH-cycle MUL/DIV, registered result and flags.
module seq_alu import alu_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] f_q, f_d, fhi_q, fhi_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;
   logic             mul_q, mul_d;
   logic             accept, start, eng_done;
   logic [WIDTH-1:0] eng_lo, eng_hi;
   logic [WIDTH:0]   sum;

   assign accept = bus.in_valid && (state_q == IDLE);
   assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
   assign start  = accept && bus.mode &&
                   ((bus.op == MUL) || ((bus.op == DIV) && (bus.b != '0)));

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .is_div_i (bus.op == DIV),
      .a_i      (bus.a),
      .b_i      (bus.b),
      .done_o   (eng_done),
      .lo_o     (eng_lo),
      .hi_o     (eng_hi)
   );

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      fhi_d   = fhi_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      mul_d   = mul_q;
      case (state_q)
         IDLE: if (accept) begin
            fhi_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = 1'b0;
            state_d = DONE;
            if (!bus.mode) begin
               case (bus.op)
                  LAND: f_d = bus.a & bus.b;
                  LOR:  f_d = bus.a | bus.b;
                  LXOR: f_d = bus.a ^ bus.b;
                  LNOT: f_d = ~bus.a;
               endcase
            end else begin
               case (bus.op)
                  ADD: {carry_d, f_d} = sum;
                  SUB: begin
                     f_d     = bus.a - bus.b;
                     carry_d = bus.a < bus.b;
                  end
                  default: if (!start) begin
                     f_d   = '1;
                     fhi_d = bus.a;
                     dz_d  = 1'b1;
                  end else begin
                     state_d = BUSY;
                     mul_d   = (bus.op == MUL);
                  end
               endcase
            end
         end
         BUSY: if (eng_done) begin
            f_d     = eng_lo;
            fhi_d   = eng_hi;
            ovf_d   = mul_q && (eng_hi != '0);
            state_d = DONE;
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // zero only tracks a freshly produced result, so it stays 0 out of reset
      if ((state_d == DONE) && (state_q != DONE)) zero_d = (f_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         f_q     <= '0;
         fhi_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         mul_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         fhi_q   <= fhi_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         mul_q   <= mul_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.f         = f_q;
   assign bus.f_hi      = fhi_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.dz        = dz_q;

endmodule
